// File: rtl/unidad_multdiv_pkg.sv
// -----------------------------------------------------------------------------
// unidad_multdiv_pkg
// Shared constants and types for the iterative multiply/divide unit:
//   - ANCHO_DEF : default operand/result width
//   - ITER      : iterations per operation (one result bit per cycle)
//   - CNT_W     : width of the iteration counter
//   - OP_*      : operation encodings carried on the 2-bit 'op' port
//   - estado_t  : control FSM states
//   - es_div / es_signado : decode helpers for the op field
// -----------------------------------------------------------------------------
package unidad_multdiv_pkg;

    localparam int ANCHO_DEF = 32;
    localparam int ITER      = 32;
    localparam int CNT_W     = 5;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
    function automatic logic es_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic es_signado(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/unidad_multdiv_abs_signo.sv
// -----------------------------------------------------------------------------
// abs_signo
// Combinational magnitude/sign extraction with an optional forced negate.
//   din       in  W  value to condition
//   con_signo in  1  treat din as two's complement (extract its sign)
//   negar     in  1  additionally negate the result
//   dout      out W  din, negated when (extracted sign XOR negar) is set
//   signo     out 1  sign bit of din when con_signo=1, else 0
// Used with con_signo=1/negar=0 to take |x| of an operand, and with
// con_signo=0/negar=cond to apply sign correction to a result.
// -----------------------------------------------------------------------------
module abs_signo #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         con_signo,
    input  logic         negar,
    output logic [W-1:0] dout,
    output logic         signo
);

    localparam logic [W-1:0] UNO = {{(W-1){1'b0}}, 1'b1};

    assign signo = con_signo & din[W-1];
    assign dout  = (signo ^ negar) ? (~din + UNO) : din;

endmodule

// File: rtl/unidad_multdiv.sv
// -----------------------------------------------------------------------------
// unidad_multdiv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One result bit per cycle: 32 CALC cycles + 1 FIN cycle, result and done
// visible 34 cycles after the start is accepted.
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      launch op (only honoured in IDLE, wins over mt_*)
//   op     in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in  ANCHO  multiplicand / dividend / mt_* write data
//   b      in  ANCHO  multiplier / divisor
//   mt_hi  in  1      IDLE write of a into HI
//   mt_lo  in  1      IDLE write of a into LO
//   hi     out ANCHO  product high half / remainder
//   lo     out ANCHO  product low half / quotient
//   busy   out 1      operation in progress
//   done   out 1      one-cycle pulse when HI/LO hold a new result
// -----------------------------------------------------------------------------
module unidad_multdiv
    import unidad_multdiv_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    output logic [ANCHO-1:0] hi,
    output logic [ANCHO-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int AW = 2 * ANCHO;

    // ---------------------------------------------------------------- state
    estado_t            estado_q, estado_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;       // shared product / {rem, quot}
    logic [ANCHO-1:0]   opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;         // sign of a (0 for unsigned ops)
    logic               sb_q, sb_d;         // sign of b (0 for unsigned ops)
    logic               bcero_q, bcero_d;   // divisor was zero
    logic [ANCHO-1:0]   hi_q, hi_d;
    logic [ANCHO-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // ---------------------------------------------------- operand conditioning
    logic               signado_in;
    logic [ANCHO-1:0]   mag_a, mag_b;
    logic               sgn_a, sgn_b;

    assign signado_in = es_signado(op);

    abs_signo #(.W(ANCHO)) u_abs_a (
        .din       (a),
        .con_signo (signado_in),
        .negar     (1'b0),
        .dout      (mag_a),
        .signo     (sgn_a)
    );

    abs_signo #(.W(ANCHO)) u_abs_b (
        .din       (b),
        .con_signo (signado_in),
        .negar     (1'b0),
        .dout      (mag_b),
        .signo     (sgn_b)
    );

    // ------------------------------------------------------- iteration steps
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the 65-bit result right.
    logic [ANCHO:0]     mul_suma;
    logic [ANCHO:0]     mul_sumando;
    logic [AW-1:0]      mul_paso;

    assign mul_sumando = acc_q[0] ? {1'b0, opnd_q} : '0;
    assign mul_suma    = {1'b0, acc_q[AW-1:ANCHO]} + mul_sumando;
    assign mul_paso    = {mul_suma, acc_q[ANCHO-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half
    // shifts the dividend out and quotient bits in. The shifted remainder
    // needs ANCHO+1 bits; one extra guard bit exposes the borrow.
    logic [ANCHO:0]     rem_desp;
    logic [ANCHO+1:0]   div_resta;
    logic               div_ok;
    logic [ANCHO-1:0]   rem_nuevo;
    logic [AW-1:0]      div_paso;

    assign rem_desp  = {acc_q[AW-1:ANCHO], acc_q[ANCHO-1]};
    assign div_resta = {1'b0, rem_desp} - {2'b00, opnd_q};
    assign div_ok    = ~div_resta[ANCHO+1];
    // With a zero divisor every step "succeeds": quotient fills with ones
    // and the remainder ends up equal to the dividend magnitude.
    assign rem_nuevo = div_ok ? div_resta[ANCHO-1:0] : rem_desp[ANCHO-1:0];
    assign div_paso  = {rem_nuevo, acc_q[ANCHO-2:0], div_ok};

    // ----------------------------------------------------- result correction
    logic [AW-1:0]      prod_corr;
    logic [ANCHO-1:0]   quot_corr, rem_corr;
    logic               signo_unused_p, signo_unused_q, signo_unused_r;

    abs_signo #(.W(AW)) u_corr_prod (
        .din       (acc_q),
        .con_signo (1'b0),
        .negar     (sa_q ^ sb_q),
        .dout      (prod_corr),
        .signo     (signo_unused_p)
    );

    // Division by zero keeps the all-ones quotient regardless of signs.
    abs_signo #(.W(ANCHO)) u_corr_quot (
        .din       (acc_q[ANCHO-1:0]),
        .con_signo (1'b0),
        .negar     ((sa_q ^ sb_q) & ~bcero_q),
        .dout      (quot_corr),
        .signo     (signo_unused_q)
    );

    // Remainder follows the dividend's sign.
    abs_signo #(.W(ANCHO)) u_corr_rem (
        .din       (acc_q[AW-1:ANCHO]),
        .con_signo (1'b0),
        .negar     (sa_q),
        .dout      (rem_corr),
        .signo     (signo_unused_r)
    );

    // ------------------------------------------------------- next-state logic
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bcero_d  = bcero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (estado_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sa_d     = sgn_a;
                    sb_d     = sgn_b;
                    bcero_d  = (b == '0);
                    cnt_d    = '0;
                    estado_d = CALC;
                    if (es_div(op)) begin
                        opnd_d = mag_b;
                        acc_d  = {{ANCHO{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{ANCHO{1'b0}}, mag_b};
                    end
                end else begin
                    if (mt_hi) hi_d = a;
                    if (mt_lo) lo_d = a;
                end
            end

            CALC: begin
                acc_d = es_div(op_q) ? div_paso : mul_paso;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) estado_d = FIN;
            end

            FIN: begin
                if (es_div(op_q)) begin
                    hi_d = rem_corr;
                    lo_d = quot_corr;
                end else begin
                    hi_d = prod_corr[AW-1:ANCHO];
                    lo_d = prod_corr[ANCHO-1:0];
                end
                done_d   = 1'b1;
                estado_d = IDLE;
            end

            default: estado_d = IDLE;
        endcase

        busy_d = (estado_d != IDLE);
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= OP_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bcero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bcero_q  <= bcero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_unidad_multdiv.sv
// -----------------------------------------------------------------------------
// tb_unidad_multdiv
// Directed self-checking bench for unidad_multdiv. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point, well away
// from the active edge. "Cycle k" means the k-th clock after the start was
// accepted.
// -----------------------------------------------------------------------------
module tb_unidad_multdiv;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    unidad_multdiv #(.ANCHO(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mt_hi (mt_hi),
        .mt_lo (mt_lo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one cycle; returns in cycle 1 of the new op.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Advances until done (bounded). cyc returns the cycle done was seen in,
    // or -1 on timeout; nbusy counts cycles with busy high on the way.
    task automatic wait_done(input int c0, output int cyc, output int nbusy);
        cyc   = c0;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) nbusy++;
            step();
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; mt_hi = 1'b0; mt_lo = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_mt_idle();
        int cyc, nb;
        a = 32'h12345678; mt_hi = 1'b1; step(); mt_hi = 1'b0;
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
        a = 32'hABCD0123; mt_lo = 1'b1; step(); mt_lo = 1'b0;
        checks++; if (lo !== 32'hABCD0123) begin errors++; $display("FAIL mtlo got %h want abcd0123", lo); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
        // start and mt_lo together: start wins, mt_lo dropped.
        mt_lo = 1'b1;
        launch(T_MULTU, 32'h10, 32'h3);
        mt_lo = 1'b0;
        checks++; if (lo !== 32'hABCD0123) begin errors++; $display("FAIL start_wins_lo got %h want abcd0123", lo); end
        wait_done(1, cyc, nb);
        checks++; if (lo !== 32'h30) begin errors++; $display("FAIL start_wins_res_lo got %h want 00000030", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL start_wins_res_hi got %h want 00000000", hi); end
        // Both mt strobes at once.
        a = 32'h0BADF00D; mt_hi = 1'b1; mt_lo = 1'b1; step(); mt_hi = 1'b0; mt_lo = 1'b0;
        checks++; if (hi !== 32'h0BADF00D || lo !== 32'h0BADF00D) begin
            errors++; $display("FAIL mt_both got hi=%h lo=%h want 0badf00d", hi, lo);
        end
        $display("mt_idle: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_multu();
        int cyc, nb;
        launch(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", cyc); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", nb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
        $display("multu ffffffff*ffffffff: hi=%h lo=%h cyc=%0d", hi, lo, cyc);
    endtask

    task automatic test_mult();
        int cyc, nb;
        launch(T_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(1, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", cyc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
        $display("mult -3*7: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int cyc, nb;
        launch(T_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(1, cyc, nb);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        $display("div -7/2: hi=%h lo=%h", hi, lo);
        // Launch in the done cycle.
        launch(T_DIVU, 32'd200, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        wait_done(1, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'h1C) begin errors++; $display("FAIL divu_lo got %h want 0000001c", lo); end
        checks++; if (hi !== 32'h4) begin errors++; $display("FAIL divu_hi got %h want 00000004", hi); end
        $display("divu 200/7: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_div_boundary();
        int cyc, nb;
        launch(T_DIVU, 32'd5, 32'd0);
        wait_done(1, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL div0_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h5) begin errors++; $display("FAIL div0_hi got %h want 00000005", hi); end
        $display("divu 5/0: hi=%h lo=%h", hi, lo);
        launch(T_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(1, cyc, nb);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL sdiv0_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL sdiv0_hi got %h want fffffff9", hi); end
        $display("div -7/0: hi=%h lo=%h", hi, lo);
        launch(T_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, cyc, nb);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi); end
        $display("div 80000000/ffffffff: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_interference();
        int cyc, nb;
        launch(T_MULTU, 32'd3, 32'd4);
        repeat (4) step();                  // now in cycle 5
        op = T_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        step(); start = 1'b0;               // cycle 6
        a = 32'h55; mt_lo = 1'b1;
        step(); mt_lo = 1'b0;               // cycle 7
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL busy_mtlo got %h want 80000000", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid got %b want 1", busy); end
        wait_done(7, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL interf_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL interf_lo got %h want 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL interf_hi got %h want 00000000", hi); end
        $display("multu 3*4 with interference: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid_op();
        int cyc, nb, ndone;
        launch(T_MULT, 32'd5, 32'd6);
        repeat (9) step();                  // now in cycle 10
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL midrst_hilo got hi=%h lo=%h want 0", hi, lo);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        launch(T_MULTU, 32'd6, 32'd7);
        wait_done(1, cyc, nb);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL post_rst_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL post_rst_res got hi=%h lo=%h want 0/0000002a", hi, lo);
        end
        $display("reset mid-op then multu 6*7: hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_mt_idle();
        test_multu();
        test_mult();
        test_back_to_back();
        test_div_boundary();
        test_interference();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
